usrt_apb_master: RTL and testbench
==================================

# usrt_apb_master

Bus-initiator block for the USRT peripheral bus. It accepts single read or write commands from a local requester and drives the APB-style setup/access handshake toward the USRT bus interface. It returns read data and completion status to the requester. It sits on the host side of the bus; its `o_P*` outputs connect directly to the `i_P*` inputs of the peripheral's bus interface, which decodes register select from `Paddr[31:30]`: 00 state, 01 tx, 10 rx, 11 none.

## Interface
- `ADDR_WIDTH`, 32, width of command address and `o_Paddr`
- `DATA_WIDTH`, 32, width of write/read data
- `TIMEOUT_CYCLES`, 16, access-phase cycles before abort (only used when `USRT_APB_TIMEOUT_EN` is defined; legal range 1–255)

Ports:
- `i_Pclk` input 1: bus clock; all logic is rising-edge.
- `i_Presetn` input 1: synchronous, active-low reset, sampled on `i_Pclk`.
- `i_Cmd_Valid` input 1: command request.
- `i_Cmd_Write` input 1: 1 = write, 0 = read.
- `i_Cmd_Addr` input ADDR_WIDTH: target address.
- `i_Cmd_Wdata` input DATA_WIDTH: write data.
- `o_Cmd_Ready` output 1: command accepted on an edge where valid and ready are both 1.
- `o_Rsp_Valid` output 1: one-cycle completion pulse.
- `o_Rsp_Rdata` output DATA_WIDTH: read data, valid with `o_Rsp_Valid` on reads.
- `o_Rsp_Err` output 1: slave error or timeout, valid with `o_Rsp_Valid`.
- `o_Paddr` output ADDR_WIDTH.
- `o_Psel` output 1.
- `o_Penable` output 1.
- `o_Pwrite` output 1.
- `o_Pwdata` output DATA_WIDTH.
- `i_Prdata` input DATA_WIDTH.
- `i_Pready` input 1.
- `i_Pslverr` input 1.

## Operation
- FSM states: IDLE, SETUP, ACCESS. All outputs are registered.
- **IDLE**
  - `o_Cmd_Ready` = 1; `o_Psel` = `o_Penable` = 0.
  - On `i_Cmd_Valid`=1, latch write/addr/wdata into `o_Pwrite`/`o_Paddr`/`o_Pwdata` and go to SETUP.
- **SETUP** (exactly 1 cycle)
  - `o_Psel` = 1, `o_Penable` = 0, `o_Cmd_Ready` = 0. Go to ACCESS.
- **ACCESS**
  - `o_Psel` = 1, `o_Penable` = 1.
  - On a cycle with `i_Pready`=1: capture `i_Prdata` (reads only; writes leave `o_Rsp_Rdata` unchanged) and `i_Pslverr`, then go to IDLE with `o_Rsp_Valid`=1 for one cycle.
  - Otherwise stay in ACCESS. Stalls are unbounded when the timeout is compiled out.
- `o_Paddr`, `o_Pwrite` and `o_Pwdata` hold stable from SETUP through the final ACCESS cycle. They also hold their values in IDLE; they are not cleared.
- `i_Cmd_*` are ignored while `o_Cmd_Ready`=0. There is no queuing: one outstanding transfer at a time.
- `i_Pready` and `i_Pslverr` are ignored outside ACCESS.
- Reset values: state IDLE; `o_Psel`, `o_Penable`, `o_Pwrite`, `o_Rsp_Valid`, `o_Rsp_Err` = 0; `o_Paddr`, `o_Pwdata`, `o_Rsp_Rdata` = 0; `o_Cmd_Ready` = 1 in the first cycle after reset is released.
- Reset asserted mid-transfer (SETUP or ACCESS): the next edge returns the block to IDLE with all outputs at reset values. No response is produced for the aborted command.

## Timing
- Command accepted at edge E0. SETUP is the cycle after E0; ACCESS starts at E0+2 cycles.
- Zero-wait slave (`i_Pready`=1 in the first ACCESS cycle): `o_Rsp_Valid` is high in the cycle after that ACCESS cycle, i.e. 3 cycles after acceptance.
- Each wait cycle (`i_Pready`=0) adds 1 cycle.
- `o_Cmd_Ready` returns to 1 in the same cycle as `o_Rsp_Valid`. Minimum issue interval is therefore 3 cycles: IDLE, SETUP, ACCESS.
- `o_Rsp_Rdata` and `o_Rsp_Err` hold their values until the next completion.

## Configuration
- Macro: `USRT_APB_TIMEOUT_EN`.
- **Defined:** an 8-bit counter clears on entry to ACCESS and increments on each ACCESS cycle with `i_Pready`=0.
  - When the counter reaches `TIMEOUT_CYCLES` with `i_Pready` still 0, the transfer aborts: next state IDLE, `o_Psel`/`o_Penable` drop, `o_Rsp_Valid`=1, `o_Rsp_Err`=1, `o_Rsp_Rdata` unchanged.
  - If `i_Pready`=1 on the same cycle the limit is reached, the transfer completes normally (ready wins).
- **Undefined:** no counter exists and ACCESS waits indefinitely.

## Test plan
- Reset: hold `i_Presetn`=0 for 2 cycles, then release → `o_Psel`=0, `o_Penable`=0, `o_Rsp_Valid`=0, `o_Cmd_Ready`=1.
- Read of the state register: addr 0x00000000, `i_Pready` tied to 1, `i_Prdata`=0xA5A5_0001 → `o_Psel` high for 2 cycles, `o_Penable` high for 1; `o_Rsp_Valid` pulses 3 cycles after acceptance with `o_Rsp_Rdata`=0xA5A5_0001 and `o_Rsp_Err`=0.
- Write to tx: addr 0x40000000, wdata 0x0000_0055, `i_Pready` low for 3 ACCESS cycles → `o_Pwrite`=1 and `o_Paddr[31:30]`=01 stable throughout; response 6 cycles after acceptance; `o_Rsp_Rdata` unchanged.
- Slave error: read of rx (addr 0x80000000) completing with `i_Pslverr`=1 → `o_Rsp_Err`=1. A second command offered during the transfer is not accepted until `o_Cmd_Ready` returns.
- Reset in ACCESS: assert `i_Presetn`=0 during the second ACCESS cycle of a stalled write → `o_Psel`/`o_Penable` are 0 after the next edge and no `o_Rsp_Valid` pulse occurs.
- With `USRT_APB_TIMEOUT_EN` and `TIMEOUT_CYCLES`=4: read of addr 0xC0000000 with `i_Pready` held at 0 → abort after 4 ACCESS cycles; `o_Rsp_Valid`=1 and `o_Rsp_Err`=1. Repeat with `i_Pready`=1 on the 4th cycle → normal completion with `o_Rsp_Err`=0.

Source files
------------

// File: rtl/usrt_apb_master.sv
// APB-style bus initiator for the USRT peripheral bus: single command in, setup/access handshake out.
// Optional access-phase timeout is compiled in with `define USRT_APB_TIMEOUT_EN.
module usrt_apb_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  i_Pclk,
  input  logic                  i_Presetn,
  input  logic                  i_Cmd_Valid,
  input  logic                  i_Cmd_Write,
  input  logic [ADDR_WIDTH-1:0] i_Cmd_Addr,
  input  logic [DATA_WIDTH-1:0] i_Cmd_Wdata,
  output logic                  o_Cmd_Ready,
  output logic                  o_Rsp_Valid,
  output logic [DATA_WIDTH-1:0] o_Rsp_Rdata,
  output logic                  o_Rsp_Err,
  output logic [ADDR_WIDTH-1:0] o_Paddr,
  output logic                  o_Psel,
  output logic                  o_Penable,
  output logic                  o_Pwrite,
  output logic [DATA_WIDTH-1:0] o_Pwdata,
  input  logic [DATA_WIDTH-1:0] i_Prdata,
  input  logic                  i_Pready,
  input  logic                  i_Pslverr
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..255");
  end

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t                state_reg, state_next;
  logic                  cmd_ready_reg, cmd_ready_next;
  logic                  rsp_valid_reg, rsp_valid_next;
  logic                  rsp_err_reg, rsp_err_next;
  logic [DATA_WIDTH-1:0] rsp_rdata_reg, rsp_rdata_next;
  logic [ADDR_WIDTH-1:0] paddr_reg, paddr_next;
  logic                  psel_reg, psel_next;
  logic                  penable_reg, penable_next;
  logic                  pwrite_reg, pwrite_next;
  logic [DATA_WIDTH-1:0] pwdata_reg, pwdata_next;
  logic                  timeout;

`ifdef USRT_APB_TIMEOUT_EN
  logic [7:0] wait_cnt_reg, wait_cnt_next;

  // This stall cycle would bring the count to the limit.
  assign timeout = (wait_cnt_reg == 8'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_next     = state_reg;
    cmd_ready_next = cmd_ready_reg;
    rsp_valid_next = 1'b0;
    rsp_err_next   = rsp_err_reg;
    rsp_rdata_next = rsp_rdata_reg;
    paddr_next     = paddr_reg;
    psel_next      = psel_reg;
    penable_next   = penable_reg;
    pwrite_next    = pwrite_reg;
    pwdata_next    = pwdata_reg;
`ifdef USRT_APB_TIMEOUT_EN
    wait_cnt_next  = wait_cnt_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (i_Cmd_Valid) begin
          paddr_next     = i_Cmd_Addr;
          pwrite_next    = i_Cmd_Write;
          pwdata_next    = i_Cmd_Wdata;
          psel_next      = 1'b1;
          penable_next   = 1'b0;
          cmd_ready_next = 1'b0;
          state_next     = SETUP;
        end
      end
      SETUP: begin
        penable_next = 1'b1;
        state_next   = ACCESS;
`ifdef USRT_APB_TIMEOUT_EN
        wait_cnt_next = 8'd0;
`endif
      end
      ACCESS: begin
        // Ready wins over a timeout landing on the same cycle.
        if (i_Pready || timeout) begin
          state_next     = IDLE;
          psel_next      = 1'b0;
          penable_next   = 1'b0;
          cmd_ready_next = 1'b1;
          rsp_valid_next = 1'b1;
          rsp_err_next   = i_Pready ? i_Pslverr : 1'b1;
          if (i_Pready && !pwrite_reg) begin
            rsp_rdata_next = i_Prdata;
          end
        end else begin
`ifdef USRT_APB_TIMEOUT_EN
          wait_cnt_next = wait_cnt_reg + 8'd1;
`endif
        end
      end
      default: begin
        state_next     = IDLE;
        psel_next      = 1'b0;
        penable_next   = 1'b0;
        cmd_ready_next = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_Pclk) begin
    if (!i_Presetn) begin
      state_reg     <= IDLE;
      cmd_ready_reg <= 1'b1;
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      rsp_rdata_reg <= '0;
      paddr_reg     <= '0;
      psel_reg      <= 1'b0;
      penable_reg   <= 1'b0;
      pwrite_reg    <= 1'b0;
      pwdata_reg    <= '0;
`ifdef USRT_APB_TIMEOUT_EN
      wait_cnt_reg  <= 8'd0;
`endif
    end else begin
      state_reg     <= state_next;
      cmd_ready_reg <= cmd_ready_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_err_reg   <= rsp_err_next;
      rsp_rdata_reg <= rsp_rdata_next;
      paddr_reg     <= paddr_next;
      psel_reg      <= psel_next;
      penable_reg   <= penable_next;
      pwrite_reg    <= pwrite_next;
      pwdata_reg    <= pwdata_next;
`ifdef USRT_APB_TIMEOUT_EN
      wait_cnt_reg  <= wait_cnt_next;
`endif
    end
  end

  assign o_Cmd_Ready = cmd_ready_reg;
  assign o_Rsp_Valid = rsp_valid_reg;
  assign o_Rsp_Err   = rsp_err_reg;
  assign o_Rsp_Rdata = rsp_rdata_reg;
  assign o_Paddr     = paddr_reg;
  assign o_Psel      = psel_reg;
  assign o_Penable   = penable_reg;
  assign o_Pwrite    = pwrite_reg;
  assign o_Pwdata    = pwdata_reg;

endmodule

// File: tb/tb_usrt_apb_master.sv
// Directed self-checking bench for usrt_apb_master; timeout cases run when USRT_APB_TIMEOUT_EN is defined.
module tb_usrt_apb_master;

  logic        i_Pclk = 1'b0;
  logic        i_Presetn;
  logic        i_Cmd_Valid;
  logic        i_Cmd_Write;
  logic [31:0] i_Cmd_Addr;
  logic [31:0] i_Cmd_Wdata;
  logic        o_Cmd_Ready;
  logic        o_Rsp_Valid;
  logic [31:0] o_Rsp_Rdata;
  logic        o_Rsp_Err;
  logic [31:0] o_Paddr;
  logic        o_Psel;
  logic        o_Penable;
  logic        o_Pwrite;
  logic [31:0] o_Pwdata;
  logic [31:0] i_Prdata;
  logic        i_Pready;
  logic        i_Pslverr;

  int tests_run    = 0;
  int tests_failed = 0;

  // Results of the latest run_txn call.
  int   lat, psel_cyc, pen_cyc;
  logic stable, busy_ok;

  always #5 i_Pclk = ~i_Pclk;

  usrt_apb_master #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .i_Pclk(i_Pclk),
    .i_Presetn(i_Presetn),
    .i_Cmd_Valid(i_Cmd_Valid),
    .i_Cmd_Write(i_Cmd_Write),
    .i_Cmd_Addr(i_Cmd_Addr),
    .i_Cmd_Wdata(i_Cmd_Wdata),
    .o_Cmd_Ready(o_Cmd_Ready),
    .o_Rsp_Valid(o_Rsp_Valid),
    .o_Rsp_Rdata(o_Rsp_Rdata),
    .o_Rsp_Err(o_Rsp_Err),
    .o_Paddr(o_Paddr),
    .o_Psel(o_Psel),
    .o_Penable(o_Penable),
    .o_Pwrite(o_Pwrite),
    .o_Pwdata(o_Pwdata),
    .i_Prdata(i_Prdata),
    .i_Pready(i_Pready),
    .i_Pslverr(i_Pslverr)
  );

  task automatic tick;
    @(posedge i_Pclk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one command and act as the slave. waits = number of ACCESS cycles with
  // Pready low before it goes high (0 = Pready tied high for the whole transfer).
  // hold_valid keeps offering a different command while the transfer is busy.
  task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int waits, input logic err,
                         input logic hold_valid);
    int acc;
    check_eq("ready_before_cmd", {63'd0, o_Cmd_Ready}, 64'd1);
    i_Cmd_Valid = 1'b1;
    i_Cmd_Write = wr;
    i_Cmd_Addr  = addr;
    i_Cmd_Wdata = wdata;
    i_Prdata    = rdata;
    i_Pslverr   = err;
    i_Pready    = (waits == 0);
    tick;
    if (hold_valid) begin
      i_Cmd_Write = ~wr;
      i_Cmd_Addr  = 32'hC000_00F0;
      i_Cmd_Wdata = 32'h7777_7777;
    end else begin
      i_Cmd_Valid = 1'b0;
    end
    lat = 0; psel_cyc = 0; pen_cyc = 0; acc = 0; stable = 1'b1; busy_ok = 1'b1;
    for (int c = 1; c <= 40 && lat == 0; c++) begin
      if (o_Rsp_Valid) begin
        lat = c;
      end else begin
        if (o_Cmd_Ready) busy_ok = 1'b0;
        if (o_Psel) begin
          psel_cyc++;
          if (o_Paddr !== addr || o_Pwrite !== wr || o_Pwdata !== wdata) stable = 1'b0;
        end
        if (o_Penable) begin
          pen_cyc++;
          acc++;
        end
        if (waits != 0) i_Pready = o_Penable && (acc > waits);
        tick;
      end
    end
    i_Cmd_Valid = 1'b0;
    i_Pready    = 1'b0;
    i_Pslverr   = 1'b0;
    $display("[TB] txn wr=%0b addr=%h wdata=%h lat=%0d rdata=%h err=%0b",
             wr, addr, wdata, lat, o_Rsp_Rdata, o_Rsp_Err);
  endtask

  task automatic check_txn(input string tag, input int exp_lat, input int exp_psel,
                           input int exp_pen, input logic [31:0] exp_rdata, input logic exp_err);
    check_eq({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check_eq({tag, "_psel_cycles"}, 64'(psel_cyc), 64'(exp_psel));
    check_eq({tag, "_penable_cycles"}, 64'(pen_cyc), 64'(exp_pen));
    check_eq({tag, "_addr_ctrl_stable"}, {63'd0, stable}, 64'd1);
    check_eq({tag, "_not_ready_busy"}, {63'd0, busy_ok}, 64'd1);
    check_eq({tag, "_rdata"}, {32'd0, o_Rsp_Rdata}, {32'd0, exp_rdata});
    check_eq({tag, "_err"}, {63'd0, o_Rsp_Err}, {63'd0, exp_err});
    check_eq({tag, "_ready_at_rsp"}, {63'd0, o_Cmd_Ready}, 64'd1);
    check_eq({tag, "_psel_at_rsp"}, {63'd0, o_Psel}, 64'd0);
    tick;
    check_eq({tag, "_rsp_pulse_end"}, {63'd0, o_Rsp_Valid}, 64'd0);
  endtask

  initial begin
    int pulses;
    i_Presetn   = 1'b0;
    i_Cmd_Valid = 1'b0;
    i_Cmd_Write = 1'b0;
    i_Cmd_Addr  = '0;
    i_Cmd_Wdata = '0;
    i_Prdata    = '0;
    i_Pready    = 1'b0;
    i_Pslverr   = 1'b0;
    tick;
    tick;
    i_Presetn = 1'b1;
    tick;
    check_eq("rst_psel", {63'd0, o_Psel}, 64'd0);
    check_eq("rst_penable", {63'd0, o_Penable}, 64'd0);
    check_eq("rst_rsp_valid", {63'd0, o_Rsp_Valid}, 64'd0);
    check_eq("rst_cmd_ready", {63'd0, o_Cmd_Ready}, 64'd1);
    check_eq("rst_paddr", {32'd0, o_Paddr}, 64'd0);

    // Read of the state register, zero-wait slave.
    run_txn(1'b0, 32'h0000_0000, 32'h0, 32'hA5A5_0001, 0, 1'b0, 1'b0);
    check_txn("rd_state", 3, 2, 1, 32'hA5A5_0001, 1'b0);

    // Write to tx with three wait states; read data must not change.
    run_txn(1'b1, 32'h4000_0000, 32'h0000_0055, 32'hDEAD_BEEF, 3, 1'b0, 1'b0);
    check_eq("wr_tx_sel_bits", {62'd0, o_Paddr[31:30]}, 64'd1);
    check_eq("wr_tx_pwrite_held", {63'd0, o_Pwrite}, 64'd1);
    check_txn("wr_tx", 6, 5, 4, 32'hA5A5_0001, 1'b0);

    // Read of rx with slave error, second command offered while busy.
    run_txn(1'b0, 32'h8000_0000, 32'h0, 32'h1234_5678, 1, 1'b1, 1'b1);
    check_txn("rd_rx_slverr", 4, 3, 2, 32'h1234_5678, 1'b1);

    // Follow-up read clears the error flag.
    run_txn(1'b0, 32'hC000_0000, 32'h0, 32'h0BAD_F00D, 0, 1'b0, 1'b0);
    check_txn("rd_none", 3, 2, 1, 32'h0BAD_F00D, 1'b0);

    // Reset during the second ACCESS cycle of a stalled write.
    i_Cmd_Valid = 1'b1;
    i_Cmd_Write = 1'b1;
    i_Cmd_Addr  = 32'h4000_0010;
    i_Cmd_Wdata = 32'h0000_00AA;
    tick;
    i_Cmd_Valid = 1'b0;
    tick;
    tick;
    check_eq("rstmid_in_access", {63'd0, o_Penable}, 64'd1);
    i_Presetn = 1'b0;
    tick;
    check_eq("rstmid_psel", {63'd0, o_Psel}, 64'd0);
    check_eq("rstmid_penable", {63'd0, o_Penable}, 64'd0);
    check_eq("rstmid_pwrite", {63'd0, o_Pwrite}, 64'd0);
    check_eq("rstmid_paddr", {32'd0, o_Paddr}, 64'd0);
    check_eq("rstmid_rdata", {32'd0, o_Rsp_Rdata}, 64'd0);
    i_Presetn = 1'b1;
    i_Pready  = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      if (o_Rsp_Valid) pulses++;
      tick;
    end
    i_Pready = 1'b0;
    check_eq("rstmid_no_rsp", 64'(pulses), 64'd0);
    check_eq("rstmid_ready", {63'd0, o_Cmd_Ready}, 64'd1);

`ifdef USRT_APB_TIMEOUT_EN
    // Slave never ready: abort after four ACCESS cycles.
    run_txn(1'b0, 32'hC000_0000, 32'h0, 32'h5555_AAAA, 100, 1'b0, 1'b0);
    check_txn("timeout_abort", 6, 5, 4, 32'h0000_0000, 1'b1);
    // Ready on the fourth ACCESS cycle wins over the timeout.
    run_txn(1'b0, 32'hC000_0000, 32'h0, 32'h5555_AAAA, 3, 1'b0, 1'b0);
    check_txn("timeout_ready_wins", 6, 5, 4, 32'h5555_AAAA, 1'b0);
`else
    // Without the timeout a long stall still completes normally.
    run_txn(1'b0, 32'hC000_0000, 32'h0, 32'h5555_AAAA, 20, 1'b0, 1'b0);
    check_txn("long_stall", 23, 22, 21, 32'h5555_AAAA, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
